// File: rtl/sat_cmd_sequencer_if.sv
// Load/command bus of sat_cmd_sequencer.
//   master : host/test side, offers literals, start and the accelerator result.
//   slave  : the sequencer, returns handshake/status and the command stream.
//   Load     : lit_valid, lit_ready, lit_var[4:0], lit_neg, lit_last
//   Control  : start, busy, done, sat_result, err
//   Command  : stateVal[1:0], varPos[4:0], negCtrl, outSATRes
interface sat_cmd_sequencer_if;
    logic       lit_valid;
    logic       lit_ready;
    logic [4:0] lit_var;
    logic       lit_neg;
    logic       lit_last;
    logic       start;
    logic       busy;
    logic       done;
    logic       sat_result;
    logic       err;
    logic [1:0] stateVal;
    logic [4:0] varPos;
    logic       negCtrl;
    logic       outSATRes;

    modport master (
        output lit_valid, lit_var, lit_neg, lit_last, start, outSATRes,
        input  lit_ready, busy, done, sat_result, err, stateVal, varPos, negCtrl
    );

    modport slave (
        input  lit_valid, lit_var, lit_neg, lit_last, start, outSATRes,
        output lit_ready, busy, done, sat_result, err, stateVal, varPos, negCtrl
    );
endinterface

// File: rtl/sat_cmd_sequencer.sv
// Host-side command generator for the SAT accelerator. Stores CNF literals
// loaded over a valid/ready port and, on start, replays them as the command
// stream {stateVal, varPos, negCtrl}, then samples and reports outSATRes.
// Ports:
//   clk    : rising-edge clock
//   resetN : asynchronous active-low reset
//   bus    : sat_cmd_sequencer_if.slave (load port, control/status, command out)
module sat_cmd_sequencer #(
    parameter int unsigned N            = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned RESET_CYCLES = 6,
    parameter int unsigned RESULT_LAT   = 2
) (
    input logic               clk,
    input logic               resetN,
    sat_cmd_sequencer_if.slave bus
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned CycMax = (RESET_CYCLES > RESULT_LAT) ? RESET_CYCLES : RESULT_LAT;
    localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;

    typedef enum logic [2:0] {StIdle, StRst, StLit, StCnf, StClr, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic              err_q, err_d, sat_q, sat_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [6:0]        mem_q [DEPTH];   // {var[4:0], neg, last}
    logic [6:0]        rd_entry, nx_entry;
    logic              lit_ready, hs, lit_ok, store, go, final_entry;

    assign lit_ready  = (state_q == StIdle) && (cnt_q != CntW'(DEPTH));
    assign hs         = bus.lit_valid && lit_ready;
    assign lit_ok     = 32'(bus.lit_var) < N;
    assign store      = hs && lit_ok;
    // A literal taken in the start cycle counts toward a non-empty store.
    assign go         = (state_q == StIdle) && bus.start && ((cnt_q != '0) || store);
    assign rd_ptr_inc = rd_ptr_q + PtrW'(1);
    assign rd_entry   = mem_q[rd_ptr_q];
    // Reading the entry just before wr_ptr means the store is exhausted;
    // this also holds for a full store where wr_ptr == rd_ptr at the start.
    assign final_entry = (rd_ptr_inc == wr_ptr_q);

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= {bus.lit_var, bus.lit_neg, bus.lit_last};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            cyc_q    <= '0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            cmd_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            cmd_q    <= cmd_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (go) state_d = StRst;
            StRst:  if (cyc_q == CycW'(RESET_CYCLES - 1)) state_d = StLit;
            StLit:  if (rd_entry[0] || final_entry) state_d = StCnf;
            StCnf:  state_d = StClr;
            StClr:  state_d = (rd_ptr_q != wr_ptr_q) ? StLit : StWait;
            StWait: if (cyc_q == CycW'(RESULT_LAT - 1)) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Store bookkeeping, phase counter and error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        cyc_d    = '0;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            cnt_d    = cnt_q + CntW'(1);
        end
        if (hs && !lit_ok) err_d = 1'b1;
        if ((state_q == StIdle) && bus.start && !go) err_d = 1'b1;
        if (state_q == StLit) rd_ptr_d = rd_ptr_inc;
        if (state_q == StDone) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
        if (((state_q == StRst) && (state_d == StRst)) ||
            ((state_q == StWait) && (state_d == StWait))) begin
            cyc_d = cyc_q + CycW'(1);
        end
    end

    // Outputs: the command register is loaded with what the next state emits.
    always_comb begin
        nx_entry = mem_q[rd_ptr_d];
        cmd_d    = cmd_q;
        sat_d    = sat_q;
        unique case (state_d)
            StIdle:  cmd_d = cmd_q;
            StRst:   cmd_d = 8'h00;
            StLit:   cmd_d = {2'b01, nx_entry[6:2], nx_entry[1]};
            StCnf:   cmd_d = 8'h80;
            default: cmd_d = 8'hC0;
        endcase
        // Only WAIT enters DONE, so result and done appear together.
        if ((state_d == StDone) && (state_q != StDone)) sat_d = bus.outSATRes;
    end

    assign bus.lit_ready  = lit_ready;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.sat_result = sat_q;
    assign bus.err        = err_q;
    assign bus.stateVal   = cmd_q[7:6];
    assign bus.varPos     = cmd_q[5:1];
    assign bus.negCtrl    = cmd_q[0];
endmodule

// File: doc/sat_cmd_sequencer.md
# sat_cmd_sequencer

Host-side command generator for `SAT_accelerator_top`.
- Accepts CNF literals over a valid/ready load port and stores them.
- On `start`, emits the 8-bit command stream `{stateVal[1:0], varPos[4:0], negCtrl}`, one command per clock, in the order the accelerator expects.
- After the stream completes, samples `outSATRes` and reports the result.
- It is the producing end of the accelerator's command interface and replaces fixed command-table drivers in system use.

## Interface
- `N`, 4: number of CNF variables; legal `lit_var` range is 0..N-1 (N ≤ 32).
- `DEPTH`, 16: literal store entries (power of 2, ≥ 2).
- `RESET_CYCLES`, 6: number of RESET (00) commands emitted at sequence start (≥ 1).
- `RESULT_LAT`, 2: cycles waited after the last command before sampling `outSATRes` (≥ 1).

- `clk`  in  1  single clock; all logic on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `lit_valid`  in  1  literal offered.
- `lit_ready`  out  1  store can accept a literal.
- `lit_var`  in  5  variable index (becomes `varPos`).
- `lit_neg`  in  1  literal is negated (becomes `negCtrl`).
- `lit_last`  in  1  literal closes its clause.
- `start`  in  1  begin emitting the stored CNF.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when `sat_result` is valid.
- `sat_result`  out  1  captured `outSATRes`.
- `err`  out  1  sticky error flag, cleared only by reset.
- `stateVal`  out  2  command opcode: 00 RESET, 01 CLAUSE literal, 10 CNF, 11 CLEAR clause.
- `varPos`  out  5  command variable index.
- `negCtrl`  out  1  command negation flag.
- `outSATRes`  in  1  accelerator result.

## Operation
- FSM states: IDLE, RST, LIT, CNF, CLR, WAIT, DONE.
- Store: DEPTH×7 bits `{var, neg, last}`, write pointer `wr_ptr`, read pointer `rd_ptr`, count `cnt` (0..DEPTH).
- **IDLE**
  - `lit_ready = (cnt != DEPTH)`. A handshake occurs when `lit_valid && lit_ready`.
  - A handshake with `lit_var >= N` is consumed but not stored, and sets `err`.
  - `start` with `cnt == 0` is ignored and sets `err`.
  - `start` with `cnt > 0` moves to RST. A literal handshaken in the same cycle as `start` is included in the sequence.
- **RST**: emit 00/0/0 for RESET_CYCLES cycles, then go to LIT.
- **LIT**: emit `{01, var, neg}` for entry `rd_ptr`, then increment `rd_ptr`.
  - Go to CNF if the entry has `last` set, or if it is the final stored entry. An unterminated final clause is closed implicitly; this does not set `err`.
  - Otherwise stay in LIT.
- **CNF**: emit 10/0/0, then go to CLR.
- **CLR**: emit 11/0/0. Go to LIT if entries remain; otherwise go to WAIT.
- **WAIT**: hold 11/0/0 for RESULT_LAT cycles, then go to DONE.
- **DONE**: capture `sat_result <= outSATRes`, pulse `done`, clear `wr_ptr`, `rd_ptr` and `cnt`, return to IDLE.
- `lit_ready` is 0 in every state except IDLE. `start` is ignored outside IDLE.
- `busy` is 1 in RST, LIT, CNF, CLR, WAIT and DONE.
- Command outputs hold 11/0/0 in IDLE after the first completed sequence.
- Pointers wrap modulo DEPTH. `cnt` arithmetic is DEPTH-exact: full at DEPTH, never overflows.

## Timing
- **Reset values**: `stateVal` = 00, `varPos` = 0, `negCtrl` = 0, `lit_ready` = 1, `busy` = 0, `done` = 0, `sat_result` = 0, `err` = 0. Store pointers and `cnt` = 0; FSM = IDLE.
- Command outputs are registered. The first RESET command appears in the cycle after `start` is sampled high.
- Stream length: RESET_CYCLES + L + 2C commands, where L = stored literals and C = clauses (including an implicitly closed one).
- `done` rises RESULT_LAT + 1 cycles after the last CLR command is presented. `sat_result` updates in the same cycle and holds until the next `done`.
- `resetN` low mid-sequence forces all reset values immediately (asynchronously) and discards stored literals.
- The store being full blocks further loads only; it has no effect on `start`.

## Test plan
- **Default params, reset**: hold `resetN` low 5 cycles → all outputs at their reset values; `lit_ready` = 1.
- **Load and run (x1+x2)(~x1+x2)**:
  - Load `{0,0,0}`, `{1,0,1}`, `{0,1,0}`, `{1,0,1}`, then pulse `start`.
  - Required byte stream: 6×0x00, 0x40, 0x42, 0x80, 0xC0, 0x41, 0x42, 0x80, 0xC0 (14 commands).
  - Then 0xC0 is held; `done` pulses 3 cycles after the final 0xC0; `sat_result` = `outSATRes` (model drives 1 → 1).
- **Full store**: offer 17 literals (last one has `lit_last`=1) → `lit_ready` drops after the 16th; 16 entries stored; `err` stays 0.
  - `start` → 16 CLAUSE commands, then 0x80, 0xC0.
- **Error cases**:
  - `lit_var` = 4 with N = 4 → accepted, not stored, `err` = 1.
  - `start` with empty store → no commands emitted.
  - `start` while `busy` → ignored; stream unchanged.
- **Same-cycle load and start**: `start` with `lit_valid` = 1 carrying `{3,1,1}` on an empty store → stream 6×0x00, 0x47, 0x80, 0xC0.
- **Reset mid-run**: assert `resetN` low during LIT → outputs 0 immediately. Then `start` without loading → ignored (store empty) and `err` = 1.
